// File: rtl/management_tx_byte_packer_pkg.sv
// Shared management definitions: frame length sizing, default frame limit and
// the byte packer state encoding.
package management_tx_byte_packer_pkg;

    localparam int MGMT_FRAME_LEN_BITS = 11;
    localparam int MGMT_MAX_FRAME_LEN  = 1522;

    typedef logic [MGMT_FRAME_LEN_BITS-1:0] frame_len_t;

    typedef enum logic [1:0] {
        PK_IDLE   = 2'd0,
        PK_SHIFT  = 2'd1,
        PK_COMMIT = 2'd2
    } packer_state_e;

    // Out-of-range byte counts (0, 5..7) mean a full word.
    function automatic logic [2:0] norm_byte_count(input logic [2:0] raw);
        logic [2:0] cnt;
        if ((raw == 3'd0) || (raw > 3'd4)) begin
            cnt = 3'd4;
        end else begin
            cnt = raw;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/management_tx_byte_packer.sv
// Serializes 32-bit management-bus frame writes into the byte-wide push port of
// the TX CDC FIFO, keeping commits separate from pushes and frames bounded.
module management_tx_byte_packer
    import management_tx_byte_packer_pkg::*;
#(
    parameter int MAX_FRAME_LEN = MGMT_MAX_FRAME_LEN
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        bus_wr_en,
    input  logic [31:0] bus_wr_data,
    input  logic [2:0]  bus_wr_bytes,
    input  logic        bus_commit,
    output logic        bus_busy,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        wr_commit,
    output logic [10:0] frame_len,
    input  logic        err_clear,
    output logic        err_overlength,
    output logic        err_dropped
);

    localparam frame_len_t MAX_LEN_C = frame_len_t'(MAX_FRAME_LEN);

    packer_state_e state_r;
    packer_state_e state_nxt_s;
    logic [31:0]   shift_r;
    logic [31:0]   shift_nxt_s;
    logic [2:0]    remain_r;
    logic [2:0]    remain_nxt_s;
    logic          commit_pend_r;
    logic          commit_pend_nxt_s;
    frame_len_t    frame_len_r;
    frame_len_t    frame_len_nxt_s;
    logic          wr_en_r;
    logic          wr_en_nxt_s;
    logic [7:0]    wr_data_r;
    logic [7:0]    wr_data_nxt_s;
    logic          wr_commit_r;
    logic          wr_commit_nxt_s;
    logic          bus_busy_r;
    logic          bus_busy_nxt_s;
    logic          err_ovl_r;
    logic          err_ovl_nxt_s;
    logic          err_drop_r;
    logic          err_drop_nxt_s;
    logic          accept_wr_s;
    logic          accept_cm_s;
    logic          drop_set_s;
    logic          ovl_set_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        accept_wr_s       = bus_wr_en & ~bus_busy_r;
        accept_cm_s       = bus_commit & ~bus_wr_en & ~bus_busy_r;
        drop_set_s        = (bus_wr_en | bus_commit) & bus_busy_r;
        // A SHIFT cycle without a push means the byte fell beyond the limit.
        ovl_set_s         = (state_r == PK_SHIFT) & ~wr_en_r;

        state_nxt_s       = state_r;
        shift_nxt_s       = shift_r;
        remain_nxt_s      = remain_r;
        commit_pend_nxt_s = commit_pend_r;

        if (state_r == PK_COMMIT) begin
            frame_len_nxt_s = '0;
        end else if (wr_en_r) begin
            frame_len_nxt_s = frame_len_r + 11'd1;
        end else begin
            frame_len_nxt_s = frame_len_r;
        end

        case (state_r)
            PK_IDLE: begin
                if (accept_wr_s) begin
                    state_nxt_s       = PK_SHIFT;
                    shift_nxt_s       = bus_wr_data;
                    remain_nxt_s      = norm_byte_count(bus_wr_bytes);
                    commit_pend_nxt_s = bus_commit;
                end else if (accept_cm_s && (frame_len_nxt_s != 11'd0)) begin
                    state_nxt_s = PK_COMMIT;
                end else begin
                    state_nxt_s = PK_IDLE;
                end
            end
            PK_SHIFT: begin
                if (remain_r > 3'd1) begin
                    shift_nxt_s  = {shift_r[23:0], 8'h00};
                    remain_nxt_s = remain_r - 3'd1;
                end else if (commit_pend_r) begin
                    state_nxt_s       = PK_COMMIT;
                    shift_nxt_s       = 32'h0000_0000;
                    remain_nxt_s      = 3'd0;
                    commit_pend_nxt_s = 1'b0;
                end else if (accept_wr_s) begin
                    // Last-byte cycle is not busy, so the next word chains in.
                    shift_nxt_s       = bus_wr_data;
                    remain_nxt_s      = norm_byte_count(bus_wr_bytes);
                    commit_pend_nxt_s = bus_commit;
                end else if (accept_cm_s && (frame_len_nxt_s != 11'd0)) begin
                    state_nxt_s  = PK_COMMIT;
                    shift_nxt_s  = 32'h0000_0000;
                    remain_nxt_s = 3'd0;
                end else begin
                    state_nxt_s  = PK_IDLE;
                    shift_nxt_s  = 32'h0000_0000;
                    remain_nxt_s = 3'd0;
                end
            end
            PK_COMMIT: begin
                state_nxt_s = PK_IDLE;
            end
            default: begin
                state_nxt_s       = PK_IDLE;
                shift_nxt_s       = 32'h0000_0000;
                remain_nxt_s      = 3'd0;
                commit_pend_nxt_s = 1'b0;
            end
        endcase

        if ((state_nxt_s == PK_SHIFT) && (frame_len_nxt_s < MAX_LEN_C)) begin
            wr_en_nxt_s   = 1'b1;
            wr_data_nxt_s = shift_nxt_s[31:24];
        end else begin
            wr_en_nxt_s   = 1'b0;
            wr_data_nxt_s = 8'h00;
        end

        if (state_nxt_s == PK_COMMIT) begin
            wr_commit_nxt_s = 1'b1;
            bus_busy_nxt_s  = 1'b1;
        end else if (state_nxt_s == PK_SHIFT) begin
            wr_commit_nxt_s = 1'b0;
            bus_busy_nxt_s  = (remain_nxt_s > 3'd1) | commit_pend_nxt_s;
        end else begin
            wr_commit_nxt_s = 1'b0;
            bus_busy_nxt_s  = 1'b0;
        end

        if (ovl_set_s) begin
            err_ovl_nxt_s = 1'b1;
        end else if (err_clear) begin
            err_ovl_nxt_s = 1'b0;
        end else begin
            err_ovl_nxt_s = err_ovl_r;
        end

        if (drop_set_s) begin
            err_drop_nxt_s = 1'b1;
        end else if (err_clear) begin
            err_drop_nxt_s = 1'b0;
        end else begin
            err_drop_nxt_s = err_drop_r;
        end
    end

    // State, shifter and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r       <= PK_IDLE;
            shift_r       <= 32'h0000_0000;
            remain_r      <= 3'd0;
            commit_pend_r <= 1'b0;
            frame_len_r   <= 11'd0;
            wr_en_r       <= 1'b0;
            wr_data_r     <= 8'h00;
            wr_commit_r   <= 1'b0;
            bus_busy_r    <= 1'b0;
            err_ovl_r     <= 1'b0;
            err_drop_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            shift_r       <= shift_nxt_s;
            remain_r      <= remain_nxt_s;
            commit_pend_r <= commit_pend_nxt_s;
            frame_len_r   <= frame_len_nxt_s;
            wr_en_r       <= wr_en_nxt_s;
            wr_data_r     <= wr_data_nxt_s;
            wr_commit_r   <= wr_commit_nxt_s;
            bus_busy_r    <= bus_busy_nxt_s;
            err_ovl_r     <= err_ovl_nxt_s;
            err_drop_r    <= err_drop_nxt_s;
        end
    end

    assign bus_busy       = bus_busy_r;
    assign wr_en          = wr_en_r;
    assign wr_data        = wr_data_r;
    assign wr_commit      = wr_commit_r;
    assign frame_len      = frame_len_r;
    assign err_overlength = err_ovl_r;
    assign err_dropped    = err_drop_r;

endmodule

// File: tb/tb_management_tx_byte_packer.sv
// Directed bench for management_tx_byte_packer: byte scoreboard on a default
// instance plus a MAX_FRAME_LEN=8 instance sharing the same stimulus.
module tb_management_tx_byte_packer;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_wr_en = 1'b0;
    logic [31:0] bus_wr_data = 32'h0;
    logic [2:0]  bus_wr_bytes = 3'd0;
    logic        bus_commit = 1'b0;
    logic        err_clear = 1'b0;

    logic        bus_busy, wr_en, wr_commit, err_overlength, err_dropped;
    logic [7:0]  wr_data;
    logic [10:0] frame_len;
    logic        bus_busy_8, wr_en_8, wr_commit_8, err_overlength_8, err_dropped_8;
    logic [7:0]  wr_data_8;
    logic [10:0] frame_len_8;

    management_tx_byte_packer dut (
        .sys_clk(sys_clk), .rst(rst), .bus_wr_en(bus_wr_en), .bus_wr_data(bus_wr_data),
        .bus_wr_bytes(bus_wr_bytes), .bus_commit(bus_commit), .bus_busy(bus_busy),
        .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit), .frame_len(frame_len),
        .err_clear(err_clear), .err_overlength(err_overlength), .err_dropped(err_dropped)
    );

    management_tx_byte_packer #(.MAX_FRAME_LEN(8)) dut8 (
        .sys_clk(sys_clk), .rst(rst), .bus_wr_en(bus_wr_en), .bus_wr_data(bus_wr_data),
        .bus_wr_bytes(bus_wr_bytes), .bus_commit(bus_commit), .bus_busy(bus_busy_8),
        .wr_en(wr_en_8), .wr_data(wr_data_8), .wr_commit(wr_commit_8), .frame_len(frame_len_8),
        .err_clear(err_clear), .err_overlength(err_overlength_8), .err_dropped(err_dropped_8)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         wr_cnt = 0, commit_cnt = 0, wr8_cnt = 0, commit8_cnt = 0;
    int         run_len = 0, last_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compares every pushed byte and watches commits.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_cnt++;
                run_len++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL unexpected_byte: observed 0x%0h expected none", wr_data);
                end else begin
                    check("byte", {24'h0, wr_data}, {24'h0, exp_q.pop_front()});
                end
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            if (wr_commit) begin
                commit_cnt++;
                check("commit_vs_wr_en", {31'h0, wr_en}, 32'h0);
            end
            if (wr_en_8) wr8_cnt++;
            if (wr_commit_8) commit8_cnt++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_busy && (k < 100)) begin
            tick();
            k++;
        end
        if (bus_busy) begin
            n_checks++;
            n_fail++;
            $error("FAIL busy_timeout: observed busy 1 expected 0 within 100 cycles");
        end
    endtask

    task automatic write_word(input logic [31:0] data, input logic [2:0] nb, input logic cm);
        int n;
        logic [31:0] d;
        wait_idle();
        n = ((nb == 3'd0) || (nb > 3'd4)) ? 4 : int'(nb);
        d = data;
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(d[31:24]);
            d = {d[23:0], 8'h00};
        end
        bus_wr_en = 1'b1;
        bus_wr_data = data;
        bus_wr_bytes = nb;
        bus_commit = cm;
        tick();
        bus_wr_en = 1'b0;
        bus_commit = 1'b0;
    endtask

    task automatic do_commit();
        wait_idle();
        bus_commit = 1'b1;
        tick();
        bus_commit = 1'b0;
    endtask

    task automatic drain();
        wait_idle();
        tick();
        tick();
        tick();
    endtask

    task automatic run_frame1(input string tag);
        int c0;
        c0 = commit_cnt;
        write_word(32'h1122_3344, 3'd4, 1'b0);
        check({tag, "_first_en"}, {31'h0, wr_en}, 32'h1);
        check({tag, "_first_byte"}, {24'h0, wr_data}, 32'h11);
        write_word(32'h5566_0000, 3'd2, 1'b1);
        tick();
        check({tag, "_last_byte"}, {24'h0, wr_data}, 32'h66);
        check({tag, "_busy_last"}, {31'h0, bus_busy}, 32'h1);
        tick();
        check({tag, "_commit"}, {31'h0, wr_commit}, 32'h1);
        check({tag, "_len_before"}, {21'h0, frame_len}, 32'd6);
        tick();
        check({tag, "_commit_off"}, {31'h0, wr_commit}, 32'h0);
        check({tag, "_len_after"}, {21'h0, frame_len}, 32'd0);
        check({tag, "_busy_after"}, {31'h0, bus_busy}, 32'h0);
        check({tag, "_commit_cnt"}, commit_cnt - c0, 32'd1);
    endtask

    initial begin
        int w0, c0, w80, c80;
        logic [31:0] word;

        // Reset values.
        #1;
        check("rst_wr_en", {31'h0, wr_en}, 32'h0);
        check("rst_busy", {31'h0, bus_busy}, 32'h0);
        check("rst_commit", {31'h0, wr_commit}, 32'h0);
        check("rst_len", {21'h0, frame_len}, 32'h0);
        check("rst_errs", {30'h0, err_overlength, err_dropped}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frame.
        run_frame1("frame1");

        // Streaming: 8 back-to-back words, the last one with byte count 0 (= 4).
        for (int i = 0; i < 8; i++) begin
            word = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            write_word(word, (i == 7) ? 3'd0 : 3'd4, 1'b0);
        end
        drain();
        check("stream_run", last_run, 32'd32);
        check("stream_len", {21'h0, frame_len}, 32'd32);
        check("stream_dropped", {31'h0, err_dropped}, 32'h0);
        c0 = commit_cnt;
        do_commit();
        drain();
        check("stream_commit", commit_cnt - c0, 32'd1);
        check("stream_len_clr", {21'h0, frame_len}, 32'd0);

        // Zero-length commit, then commit after a 1-byte word.
        c0 = commit_cnt;
        do_commit();
        drain();
        check("zero_commit", commit_cnt - c0, 32'd0);
        check("zero_errs", {30'h0, err_overlength, err_dropped}, 32'h0);
        write_word(32'hA500_0000, 3'd1, 1'b0);
        check("one_byte_busy", {31'h0, bus_busy}, 32'h0);
        do_commit();
        drain();
        check("one_byte_commit", commit_cnt - c0, 32'd1);

        // Overlength on the 8-byte instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        w0 = wr_cnt; c0 = commit_cnt; w80 = wr8_cnt; c80 = commit8_cnt;
        write_word(32'h0102_0304, 3'd4, 1'b0);
        write_word(32'h0506_0708, 3'd4, 1'b0);
        write_word(32'h090A_0B0C, 3'd4, 1'b1);
        drain();
        check("ovl_wr8", wr8_cnt - w80, 32'd8);
        check("ovl_flag8", {31'h0, err_overlength_8}, 32'h1);
        check("ovl_commit8", commit8_cnt - c80, 32'd1);
        check("ovl_wr_dflt", wr_cnt - w0, 32'd12);
        check("ovl_flag_dflt", {31'h0, err_overlength}, 32'h0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovl_clear8", {31'h0, err_overlength_8}, 32'h0);

        // Write while busy.
        w0 = wr_cnt;
        write_word(32'hDEAD_BEEF, 3'd4, 1'b0);
        bus_wr_en = 1'b1;
        bus_wr_data = 32'h1234_5678;
        bus_wr_bytes = 3'd4;
        tick();
        bus_wr_en = 1'b0;
        drain();
        check("drop_flag", {31'h0, err_dropped}, 32'h1);
        check("drop_bytes", wr_cnt - w0, 32'd4);
        do_commit();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        drain();
        check("drop_clear", {31'h0, err_dropped}, 32'h0);

        // Async reset during byte 2 of 4.
        write_word(32'hCAFE_F00D, 3'd4, 1'b0);
        tick();
        check("rst_mid_byte2", {24'h0, wr_data}, 32'hFE);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out", {22'h0, wr_en, wr_commit, bus_busy, err_dropped, err_overlength, wr_data == 8'h00 ? 1'b0 : 1'b1, 4'h0}, 32'h0);
        check("rst_mid_len", {21'h0, frame_len}, 32'h0);
        exp_q.delete();
        w0 = wr_cnt;
        c0 = commit_cnt;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rst_mid_no_wr", wr_cnt - w0, 32'd0);
        check("rst_mid_no_commit", commit_cnt - c0, 32'd0);
        check("rst_mid_len_post", {21'h0, frame_len}, 32'h0);
        run_frame1("frame2");
        drain();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
